// File: rtl/cache_controller_if.sv
// Bus bundle between the MEM stage, the cache controller and the SRAM controller.
//
// Handshake semantics (both sides): a requester raises its enable (rdEn/wrEn,
// sram_rdEn/sram_wrEn) and holds address/data stable; the responder signals
// completion with a one-cycle ready pulse (ready / sram_ready). The transfer
// happens on the clock edge at the end of the cycle in which ready is high; the
// request may drop or change only after that edge.
interface cache_controller_if;
  // MEM-stage side
  logic        wrEn;
  logic        rdEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  // SRAM-controller side
  logic        sram_wrEn;
  logic        sram_rdEn;
  logic [31:0] sram_address;
  logic [31:0] sram_writeData;
  logic [31:0] sram_readData;
  logic        sram_ready;
  // controller state, for observation only
  logic [1:0]  dbg_state;

  // environment: MEM stage plus SRAM controller
  modport master (
    output wrEn, rdEn, address, writeData, sram_readData, sram_ready,
    input  readData, ready, sram_wrEn, sram_rdEn, sram_address, sram_writeData,
    input  dbg_state
  );

  // the cache controller itself
  modport slave (
    input  wrEn, rdEn, address, writeData, sram_readData, sram_ready,
    output readData, ready, sram_wrEn, sram_rdEn, sram_address, sram_writeData,
    output dbg_state
  );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Read hits answer combinationally; read misses fill a two-word line from SRAM;
// every write goes to SRAM and also patches the cached word on a hit.
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10
) (
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);

  localparam int SETS    = 1 << INDEX_W;
  localparam int TAG_LSB = INDEX_W + 3;
  localparam int TAG_MSB = INDEX_W + 2 + TAG_W;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, WRITE} state_t;

  state_t state, state_next;

  // per-set status: valid bit per way and the index of the LRU way
  logic [SETS-1:0]  valid0, valid1, lru;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic [63:0]      line0 [SETS];
  logic [63:0]      line1 [SETS];
  logic [31:0]      buf0;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               word_sel;
  logic               hit0, hit1, hit, hit_way, victim;
  logic [63:0]        hit_line;
  logic [31:0]        hit_word;
  logic               buf_load, fill_write, lru_touch, write_hit;
  logic               unused_addr_bits;

  assign idx      = bus.address[INDEX_W+2:3];
  assign req_tag  = bus.address[TAG_MSB:TAG_LSB];
  assign word_sel = bus.address[2];
  assign unused_addr_bits = ^bus.address[1:0];

  // At most one way can match because a line is only ever filled on a miss.
  assign hit0     = valid0[idx] && (tag0[idx] == req_tag);
  assign hit1     = valid1[idx] && (tag1[idx] == req_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit1 ? line1[idx] : line0[idx];
  assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];

  // Fill empty ways first (way0 before way1), then replace the LRU way.
  assign victim = !valid0[idx] ? 1'b0 :
                  !valid1[idx] ? 1'b1 : lru[idx];

  assign bus.dbg_state = state;

  // State register; reset aborts any fill or write immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Valid and LRU bits: cleared on reset, updated on fill and on any hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (fill_write) begin
      if (victim) valid1[idx] <= 1'b1;
      else        valid0[idx] <= 1'b1;
      lru[idx] <= ~victim;
    end else if (lru_touch) begin
      lru[idx] <= ~hit_way;
    end
  end

  // Tag/data arrays and the first-word buffer; contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (buf_load) buf0 <= bus.sram_readData;
    if (fill_write) begin
      if (victim) begin
        tag1[idx]  <= req_tag;
        line1[idx] <= {bus.sram_readData, buf0};
      end else begin
        tag0[idx]  <= req_tag;
        line0[idx] <= {bus.sram_readData, buf0};
      end
    end
    if (write_hit) begin
      if (hit_way) begin
        if (word_sel) line1[idx][63:32] <= bus.writeData;
        else          line1[idx][31:0]  <= bus.writeData;
      end else begin
        if (word_sel) line0[idx][63:32] <= bus.writeData;
        else          line0[idx][31:0]  <= bus.writeData;
      end
    end
  end

  // Next state, MEM-side response and SRAM request generation.
  always_comb begin
    state_next         = state;
    bus.ready          = ~(bus.wrEn | bus.rdEn);
    bus.readData       = '0;
    bus.sram_rdEn      = 1'b0;
    bus.sram_wrEn      = 1'b0;
    bus.sram_address   = '0;
    bus.sram_writeData = '0;
    buf_load           = 1'b0;
    fill_write         = 1'b0;
    lru_touch          = 1'b0;
    write_hit          = 1'b0;

    case (state)
      IDLE: begin
        if (bus.wrEn) begin
          // writes win over reads; the cached copy is patched on entry
          state_next = WRITE;
          if (hit) begin
            write_hit = 1'b1;
            lru_touch = 1'b1;
          end
        end else if (bus.rdEn) begin
          if (hit) begin
            bus.ready    = 1'b1;
            bus.readData = hit_word;
            lru_touch    = 1'b1;
          end else begin
            state_next = FILL0;
          end
        end
      end
      FILL0: begin
        bus.sram_rdEn    = 1'b1;
        bus.sram_address = {bus.address[31:3], 3'b000};
        if (bus.sram_ready) begin
          buf_load   = 1'b1;
          state_next = FILL1;
        end
      end
      FILL1: begin
        bus.sram_rdEn    = 1'b1;
        bus.sram_address = {bus.address[31:3], 3'b100};
        if (bus.sram_ready) begin
          // requested word is forwarded from the incoming pair, not the array
          fill_write   = 1'b1;
          bus.ready    = 1'b1;
          bus.readData = word_sel ? bus.sram_readData : buf0;
          state_next   = IDLE;
        end
      end
      WRITE: begin
        bus.sram_wrEn      = 1'b1;
        bus.sram_address   = {bus.address[31:2], 2'b00};
        bus.sram_writeData = bus.writeData;
        if (bus.sram_ready) begin
          bus.ready  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // while reset is held the MEM side sees an idle, ready cache
    if (!rst) begin
      bus.ready    = 1'b1;
      bus.readData = '0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: an SRAM responder with random
// latency, a line-level LRU reference model and scenario tasks.
module tb_cache_controller;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_controller_if cif();

  cache_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (cif.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- shared bench state ----------------
  logic [31:0] sram_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [64:0] log_q [$];   // {wr, addr, data} seen by the SRAM responder
  logic [64:0] exp_q [$];   // {wr, addr, data} required by the model
  logic [31:0] cached [$];  // cached line addresses, most recently used first
  bit          hold_fill1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // ---------------- SRAM responder ----------------
  initial begin : sram_model
    bit busy;
    int lat;
    busy = 0;
    lat  = 0;
    cif.sram_ready    = 1'b0;
    cif.sram_readData = '0;
    forever begin
      @(negedge clk);
      if (cif.sram_rdEn || cif.sram_wrEn) begin
        if (!busy) begin
          busy = 1;
          lat  = $urandom_range(0, 2);
        end
        if (lat == 0) begin
          if (!(hold_fill1 && cif.sram_rdEn && cif.sram_address[2])) begin
            cif.sram_ready = 1'b1;
            busy = 0;
            if (cif.sram_wrEn) begin
              sram_mem[cif.sram_address] = cif.sram_writeData;
              log_q.push_back({1'b1, cif.sram_address, cif.sram_writeData});
            end else begin
              cif.sram_readData = sram_word(cif.sram_address);
              log_q.push_back({1'b0, cif.sram_address, 32'h0});
            end
          end
        end else begin
          lat--;
        end
      end else begin
        busy = 0;
      end
      @(posedge clk);
      #1;
      cif.sram_ready = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Cache = at most two most-recently-used lines per set; write-through, no allocate.
  task automatic model_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              output bit hit, output logic [31:0] rdata);
    logic [31:0] wa, line;
    int pos, cnt, last;
    wa   = {a[31:2], 2'b00};
    line = {a[31:3], 3'b000};
    pos  = -1;
    foreach (cached[i]) if (cached[i] == line) pos = i;
    hit   = (pos >= 0);
    rdata = '0;
    if (hit) begin
      cached.delete(pos);
      cached.push_front(line);
    end
    if (wr) begin
      ref_mem[wa] = d;
      exp_q.push_back({1'b1, wa, d});
    end else begin
      if (!hit) begin
        exp_q.push_back({1'b0, line, 32'h0});
        exp_q.push_back({1'b0, line | 32'h4, 32'h0});
        cached.push_front(line);
        cnt  = 0;
        last = -1;
        foreach (cached[i]) begin
          if (cached[i][8:3] == line[8:3]) begin
            cnt++;
            last = i;
          end
        end
        if (cnt > 2) cached.delete(last);
      end
      rdata = ref_word(wa);
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the request completes.
  task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       output bit first_rdy, output logic [31:0] rdata,
                       output bit saw_rd, output bit saw_wr);
    bit done;
    cif.wrEn      = wr;
    cif.rdEn      = rd;
    cif.address   = a;
    cif.writeData = d;
    first_rdy = 0;
    saw_rd    = 0;
    saw_wr    = 0;
    rdata     = '0;
    done      = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      #2;
      if (cif.sram_rdEn) saw_rd = 1;
      if (cif.sram_wrEn) saw_wr = 1;
      if (cif.ready) begin
        done  = 1;
        first_rdy = (c == 0);
        rdata = cif.readData;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout addr=%h: ready never rose within 60 cycles", a);
    end
    @(posedge clk);
    #1;
    cif.wrEn      = 1'b0;
    cif.rdEn      = 1'b0;
    cif.address   = '0;
    cif.writeData = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    cif.wrEn = 0; cif.rdEn = 0; cif.address = '0; cif.writeData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    checks++;
    if (cif.ready !== 1'b1 || cif.readData !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem ready=%b readData=%h, required 1 / 00000000", cif.ready, cif.readData);
    end
    checks++;
    if (cif.sram_rdEn !== 1'b0 || cif.sram_wrEn !== 1'b0) begin
      errors++;
      $display("FAIL reset_sram_en rd=%b wr=%b, required 0 / 0", cif.sram_rdEn, cif.sram_wrEn);
    end
    checks++;
    if (cif.sram_address !== 32'h0 || cif.sram_writeData !== 32'h0) begin
      errors++;
      $display("FAIL reset_sram_bus addr=%h data=%h, required 0 / 0", cif.sram_address, cif.sram_writeData);
    end
    checks++;
    if (cif.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state state=%0d, required 0", cif.dbg_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (cif.ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready ready=%b, required 1", cif.ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs a table of accesses; exp_hit_tbl gives the hit/miss outcome each must have.
  task automatic run_table(input string name, input int n, input logic [31:0] addr_tbl [8],
                           input bit wr_tbl [8], input bit rd_tbl [8], input logic [31:0] data_tbl [8],
                           input bit exp_hit_tbl [8]);
    bit first, saw_rd, saw_wr, mhit, seq_ok;
    logic [31:0] rdata, mdata;
    for (int i = 0; i < n; i++) begin
      model_access(wr_tbl[i], addr_tbl[i], data_tbl[i], mhit, mdata);
      issue(wr_tbl[i], rd_tbl[i], addr_tbl[i], data_tbl[i], first, rdata, saw_rd, saw_wr);
      checks++;
      if (first !== (exp_hit_tbl[i] && !wr_tbl[i]) || mhit !== exp_hit_tbl[i]) begin
        errors++;
        $display("FAIL %s_hit[%0d] addr=%h ready_first=%b model_hit=%b, required hit=%b",
                 name, i, addr_tbl[i], first, mhit, exp_hit_tbl[i]);
      end
      if (!wr_tbl[i]) begin
        checks++;
        if (rdata !== mdata) begin
          errors++;
          $display("FAIL %s_data[%0d] addr=%h readData=%h, required %h", name, i, addr_tbl[i], rdata, mdata);
        end
      end else begin
        checks++;
        if (saw_rd !== 1'b0 || saw_wr !== 1'b1) begin
          errors++;
          $display("FAIL %s_wr_only[%0d] sram_rdEn_seen=%b sram_wrEn_seen=%b, required 0 / 1",
                   name, i, saw_rd, saw_wr);
        end
      end
      checks++;
      seq_ok = (log_q.size() == exp_q.size());
      if (seq_ok) foreach (log_q[k]) if (log_q[k] !== exp_q[k]) seq_ok = 0;
      if (!seq_ok) begin
        errors++;
        $display("FAIL %s_sram_seq[%0d] got %0d txns (first %h), required %0d (first %h)", name, i,
                 log_q.size(), (log_q.size() > 0) ? log_q[0] : 65'h0,
                 exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 65'h0);
      end
      log_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_cold_read();
    logic [31:0] a [8] = '{32'h40, 32'h44, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] d [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    run_table("cold", 2, a, w, r, d, h);
  endtask

  task automatic test_write_hit();
    logic [31:0] a [8] = '{32'h40, 32'h44, 32'h44, 32'h40, 0, 0, 0, 0};
    bit          w [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] d [8] = '{0, 32'h12345678, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_table("write_hit", 4, a, w, r, d, h);
    checks++;
    if (ref_word(32'h44) !== 32'h12345678 || sram_word(32'h44) !== 32'h12345678) begin
      errors++;
      $display("FAIL write_hit_sram sram[44]=%h, required 12345678", sram_word(32'h44));
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] a [8] = '{32'h1000, 32'h1000, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] d [8] = '{32'hCAFE1000, 0, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("write_miss", 2, a, w, r, d, h);
  endtask

  task automatic test_eviction();
    logic [31:0] a [8] = '{32'h000, 32'h200, 32'h400, 32'h000, 32'h200, 32'h200, 0, 0};
    bit          w [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic [31:0] d [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    run_table("evict", 6, a, w, r, d, h);
  endtask

  task automatic test_rd_wr_both();
    logic [31:0] a [8] = '{32'h80, 32'h84, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] d [8] = '{32'h0BAD0080, 32'h0BAD0084, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_table("both", 2, a, w, r, d, h);
  endtask

  task automatic test_random();
    bit first, saw_rd, saw_wr, mhit, seq_ok, wr, rd;
    logic [31:0] a, dat, rdata, mdata;
    int sel;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3) |
          ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
      dat = $urandom;
      sel = $urandom_range(0, 9);
      wr  = (sel < 3);
      rd  = !wr || (sel == 0);
      model_access(wr, a, dat, mhit, mdata);
      issue(wr, rd, a, dat, first, rdata, saw_rd, saw_wr);
      checks++;
      if (first !== (mhit && !wr)) begin
        errors++;
        $display("FAIL rand_hit[%0d] addr=%h wr=%b ready_first=%b, required %b", i, a, wr, first, mhit && !wr);
      end
      if (!wr) begin
        checks++;
        if (rdata !== mdata) begin
          errors++;
          $display("FAIL rand_data[%0d] addr=%h readData=%h, required %h", i, a, rdata, mdata);
        end
      end
      checks++;
      seq_ok = (log_q.size() == exp_q.size());
      if (seq_ok) foreach (log_q[k]) if (log_q[k] !== exp_q[k]) seq_ok = 0;
      if (!seq_ok) begin
        errors++;
        $display("FAIL rand_sram_seq[%0d] addr=%h got %0d txns (first %h), required %0d (first %h)", i, a,
                 log_q.size(), (log_q.size() > 0) ? log_q[0] : 65'h0,
                 exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 65'h0);
      end
      log_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_fill();
    bit seen;
    logic [31:0] a [8] = '{32'h40, 32'h40, 0, 0, 0, 0, 0, 0};
    bit          w [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          r [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] d [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit          h [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    hold_fill1  = 1;
    cif.rdEn    = 1'b1;
    cif.address = 32'h0001_0040;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      #2;
      if (cif.sram_rdEn && cif.sram_address == 32'h0001_0044) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midfill_reach second fill read to 00010044 never presented");
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (cif.sram_rdEn !== 1'b0) begin
      errors++;
      $display("FAIL midfill_rdEn sram_rdEn=%b right after async reset, required 0", cif.sram_rdEn);
    end
    checks++;
    if (cif.ready !== 1'b1 || cif.readData !== 32'h0 || cif.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL midfill_outputs ready=%b readData=%h state=%0d, required 1 / 0 / 0",
               cif.ready, cif.readData, cif.dbg_state);
    end
    cif.rdEn    = 1'b0;
    cif.address = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    hold_fill1 = 0;
    cached.delete();
    log_q.delete();
    exp_q.delete();
    run_table("after_reset", 2, a, w, r, d, h);
  endtask

  // ---------------- sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    hold_fill1 = 0;
    sram_mem[32'h40] = 32'hAAAA0000;
    sram_mem[32'h44] = 32'hAAAA0001;
    ref_mem[32'h40]  = 32'hAAAA0000;
    ref_mem[32'h44]  = 32'hAAAA0001;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_write_miss();
    test_eviction();
    test_rd_wr_both();
    test_random();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Read hits return data in the same cycle.
- Read misses perform a two-word line fill through the SRAM controller's 32-bit interface.
- Writes are always forwarded to SRAM, and also update the cached copy on a hit.
- The MEM stage freezes the pipeline while `ready` is low.

Parameters:
- INDEX_W, 6, set index width (64 sets).
- TAG_W, 10, tag width. Address split: tag = addr[8+TAG_W:9], index = addr[8:3], word select = addr[2]; addr[1:0] ignored.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- wrEn  input  1  MEM-stage write request
- rdEn  input  1  MEM-stage read request
- address  input  32  byte address, already offset by MEM stage
- writeData  input  32  store data
- readData  output  32  load data, valid when ready=1 and rdEn=1
- ready  output  1  0 = request pending, MEM must hold inputs stable
- sram_wrEn  output  1  write request to SRAM controller
- sram_rdEn  output  1  read request to SRAM controller
- sram_address  output  32  word address to SRAM controller
- sram_writeData  output  32  write data to SRAM controller
- sram_readData  input  32  read data from SRAM controller
- sram_ready  input  1  SRAM controller completion; 0 while its request is unfinished

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all valid bits=0; all LRU bits=0; sram_rdEn=sram_wrEn=0.
  - Reset values: ready=1, readData=0, sram_address=0, sram_writeData=0.
  - Tag and data arrays need no reset.
- Storage per set: 2 ways × {valid, tag, 64-bit line}, plus 1 LRU bit holding the index of the least-recently-used way.
- Hit: valid & tag match in either way (at most one way matches by construction).
- Priority: wrEn dominates when wrEn and rdEn are both high (treated as a write).
- ready is combinational: ready = ~(wrEn|rdEn) | (IDLE & read hit) | completion cycle of WRITE or FILL1.
- States:
  - IDLE
    - rdEn & hit: ready=1; readData = hit way's word[addr[2]]; LRU = ~hitway; stay IDLE.
    - rdEn & miss: go to FILL0.
    - wrEn: go to WRITE; on hit, update the hit way's word[addr[2]] and set LRU = ~hitway (the update may occur at entry or at completion).
    - Otherwise: idle.
  - FILL0
    - Drive sram_rdEn=1 and sram_address = {addr[31:3],1'b0,2'b00}.
    - When sram_ready=1: latch sram_readData into buf0; go to FILL1.
  - FILL1
    - Drive sram_rdEn=1 and sram_address = {addr[31:3],1'b1,2'b00}.
    - When sram_ready=1: write line {sram_readData, buf0} into victim way; set valid=1 and tag; LRU = ~victim.
    - Same cycle: ready=1, readData = requested word taken from the incoming pair, not from the array. Go to IDLE.
  - WRITE
    - Drive sram_wrEn=1, sram_address = {addr[31:2],2'b00}, sram_writeData = writeData.
    - When sram_ready=1: ready=1; go to IDLE.
- Victim selection: way0 if invalid, else way1 if invalid, else the LRU way.
- SRAM handshake:
  - Request held stable until the cycle sram_ready=1; the request drops or changes on the next clock.
  - FILL0→FILL1 presents a new address back-to-back; the SRAM controller accepts a new request the cycle after completion.
- Write miss: SRAM write only; no allocation; cache contents and LRU unchanged.
- Requests from MEM: the MEM stage may deassert its request only after ready=1. A request that changes mid-fill is undefined.
- Reset mid-operation: abort immediately to IDLE with all lines invalid; the outstanding SRAM request drops asynchronously.

Test Plan:
- Cold read addr 0x40, SRAM word0=0xAAAA0000, word1=0xAAAA0001:
  - ready stays 0 through two SRAM reads (addresses 0x40, 0x44); readData=0xAAAA0000 on the completion cycle.
  - Next read of 0x44 → ready=1 same cycle, readData=0xAAAA0001, no SRAM request.
- Read addresses 0x000, 0x200, 0x400 (same index 0, three tags), then re-read 0x000 and 0x200:
  - The third fill evicts way0 (tag of 0x000).
  - Re-read 0x000 misses; re-read 0x200 then misses too, because 0x200 was LRU and was evicted by the 0x000 refill.
- Write hit: after filling 0x40, write 0x12345678 to 0x44:
  - sram_wrEn=1 at 0x44 until sram_ready; then a read of 0x44 hits, returning 0x12345678.
- Write miss to 0x1000 with sets empty:
  - SRAM write occurs; a subsequent read of 0x1000 misses (no allocate).
- Simultaneous rdEn=wrEn=1 to 0x80 → handled as write: sram_wrEn asserted, sram_rdEn stays 0.
- Assert rst=0 during FILL1 → sram_rdEn falls without a clock edge; after release, a read of a previously cached address misses.
